// File: rtl/column_drawer.sv
// Draws one vertical screen column as ceiling / wall / floor bands,
// emitting one VGA plot strobe per row from the top of the screen down.
module column_drawer #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic [7:0] x,
  input  logic [6:0] wall_top,
  input  logic [6:0] wall_bot,
  input  logic [2:0] ceil_colour,
  input  logic [2:0] wall_colour,
  input  logic [2:0] floor_colour,
  output logic       busy,
  output logic       done,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_write
);

  localparam logic [8:0] X_LIM    = 9'(SCREEN_W);
  localparam logic [6:0] LAST_ROW = 7'(SCREEN_H - 1);

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  state_t     state_q, state_d;
  logic [6:0] top_q, top_d;
  logic [6:0] bot_q, bot_d;
  logic [2:0] ceil_q, ceil_d;
  logic [2:0] wall_q, wall_d;
  logic [2:0] floor_q, floor_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [7:0] vga_x_q, vga_x_d;
  logic [6:0] vga_y_q, vga_y_d;
  logic [2:0] vga_colour_q, vga_colour_d;
  logic       vga_write_q, vga_write_d;

  // Band priority: ceiling above wall_top, then wall through wall_bot, then floor.
  // An inverted wall (top > bot) falls straight through to floor.
  function automatic logic [2:0] pick(input logic [6:0] y, input logic [6:0] top,
                                      input logic [6:0] bot, input logic [2:0] c,
                                      input logic [2:0] w, input logic [2:0] f);
    if (y < top)       return c;
    else if (y <= bot) return w;
    else               return f;
  endfunction

  always_comb begin
    state_d      = state_q;
    top_d        = top_q;
    bot_d        = bot_q;
    ceil_d       = ceil_q;
    wall_d       = wall_q;
    floor_d      = floor_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_colour_d = vga_colour_q;
    vga_write_d  = vga_write_q;

    case (state_q)
      DRAW: begin
        if (vga_y_q == LAST_ROW) begin
          state_d     = DONE;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          vga_write_d = 1'b0;
        end else begin
          vga_y_d      = vga_y_q + 7'd1;
          vga_colour_d = pick(vga_y_q + 7'd1, top_q, bot_q, ceil_q, wall_q, floor_q);
        end
      end
      default: begin
        // IDLE and DONE both accept a new column; DONE without start falls back to IDLE
        state_d     = IDLE;
        busy_d      = 1'b0;
        vga_write_d = 1'b0;
        if (start) begin
          top_d   = wall_top;
          bot_d   = wall_bot;
          ceil_d  = ceil_colour;
          wall_d  = wall_colour;
          floor_d = floor_colour;
          if ({1'b0, x} < X_LIM) begin
            state_d      = DRAW;
            busy_d       = 1'b1;
            vga_write_d  = 1'b1;
            vga_x_d      = x;
            vga_y_d      = 7'd0;
            vga_colour_d = pick(7'd0, wall_top, wall_bot, ceil_colour, wall_colour,
                                floor_colour);
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q      <= IDLE;
      top_q        <= '0;
      bot_q        <= '0;
      ceil_q       <= '0;
      wall_q       <= '0;
      floor_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      vga_write_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      top_q        <= top_d;
      bot_q        <= bot_d;
      ceil_q       <= ceil_d;
      wall_q       <= wall_d;
      floor_q      <= floor_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      vga_write_q  <= vga_write_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign vga_write  = vga_write_q;

endmodule

// File: tb/tb_column_drawer.sv
// Table-driven and randomized checks of column_drawer against a per-pixel band model.
module tb_column_drawer;
  localparam int W = 160;
  localparam int H = 120;

  logic       clock = 1'b0;
  logic       resetn, start;
  logic [7:0] x;
  logic [6:0] wall_top, wall_bot;
  logic [2:0] ceil_colour, wall_colour, floor_colour;
  logic       busy, done, vga_write;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;

  column_drawer #(.SCREEN_W(W), .SCREEN_H(H)) dut (
    .clock(clock), .resetn(resetn), .start(start), .x(x),
    .wall_top(wall_top), .wall_bot(wall_bot),
    .ceil_colour(ceil_colour), .wall_colour(wall_colour), .floor_colour(floor_colour),
    .busy(busy), .done(done), .vga_x(vga_x), .vga_y(vga_y),
    .vga_colour(vga_colour), .vga_write(vga_write)
  );

  always #5 clock = ~clock;

  typedef struct {
    int x; int top; int bot; int c; int w; int f;
    int n_ceil; int n_wall; int n_floor;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  int cap_x[$], cap_y[$], cap_c[$];
  int done_cyc, busy_bad;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int ref_col(input int y, input int top, input int bot,
                                 input int c, input int w, input int f);
    if (y < top) return c;
    if (y <= bot) return w;
    return f;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input int cx, input int top, input int bot,
                       input int c, input int w, input int f);
    x = 8'(cx); wall_top = 7'(top); wall_bot = 7'(bot);
    ceil_colour = 3'(c); wall_colour = 3'(w); floor_colour = 3'(f);
  endtask

  task automatic scramble();
    drive($urandom_range(0, 255), $urandom_range(0, 127), $urandom_range(0, 127),
          $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
  endtask

  // Called at cycle 1 (one sample after the accepting edge); records writes until done.
  task automatic collect(input int pulse_at);
    cap_x.delete(); cap_y.delete(); cap_c.delete();
    busy_bad = 0;
    done_cyc = -1;
    for (int cyc = 1; cyc <= H + 20; cyc++) begin
      if (vga_write) begin
        cap_x.push_back(int'(vga_x));
        cap_y.push_back(int'(vga_y));
        cap_c.push_back(int'(vga_colour));
      end
      if (busy != vga_write) busy_bad++;
      if (done) begin
        done_cyc = cyc;
        break;
      end
      start = (cyc == pulse_at);
      step();
    end
    start = 1'b0;
  endtask

  task automatic verify(input string tag, input int cx, input int top, input int bot,
                        input int c, input int w, input int f);
    int bad, first;
    bool_onscreen: begin end
    check({tag, " done_cycle"}, done_cyc, (cx < W) ? H + 1 : 1);
    check({tag, " write_count"}, cap_y.size(), (cx < W) ? H : 0);
    bad = 0; first = -1;
    foreach (cap_y[i]) begin
      if (cap_x[i] != cx || cap_y[i] != i || cap_c[i] != ref_col(i, top, bot, c, w, f)) begin
        bad++;
        if (first < 0) first = i;
      end
    end
    if (bad != 0) $display("  %s first bad write index %0d", tag, first);
    check({tag, " bad_pixels"}, bad, 0);
    check({tag, " busy_vs_write"}, busy_bad, 0);
    if (cx < W) begin
      check({tag, " hold_y"}, int'(vga_y), H - 1);
      check({tag, " hold_colour"}, int'(vga_colour), ref_col(H - 1, top, bot, c, w, f));
    end
  endtask

  task automatic run_col(input string tag, input int cx, input int top, input int bot,
                         input int c, input int w, input int f, input int pulse_at);
    drive(cx, top, bot, c, w, f);
    start = 1'b1;
    step();
    start = 1'b0;
    scramble();
    collect(pulse_at);
    verify(tag, cx, top, bot, c, w, f);
  endtask

  initial begin
    vec_t tbl[8];
    int nc, nw, nf, nwr, nd, cyc;
    int rx, rt, rb, rc, rw, rf;

    tbl[0] = '{5,   40,  79,  1, 4, 2, 40,  40,  40};
    tbl[1] = '{10,  90,  10,  1, 4, 2, 90,  0,   30};
    tbl[2] = '{0,   0,   127, 3, 5, 6, 0,   120, 0};
    tbl[3] = '{159, 125, 127, 1, 4, 2, 120, 0,   0};
    tbl[4] = '{160, 40,  79,  1, 4, 2, 0,   0,   0};
    tbl[5] = '{159, 0,   0,   7, 4, 2, 0,   1,   119};
    tbl[6] = '{100, 119, 119, 1, 4, 2, 119, 1,   0};
    tbl[7] = '{255, 0,   127, 1, 4, 2, 0,   0,   0};

    resetn = 1'b0; start = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    step(); step();
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset write", vga_write, 0);
    check("reset vga_x", int'(vga_x), 0);
    check("reset vga_y", int'(vga_y), 0);
    check("reset colour", int'(vga_colour), 0);
    resetn = 1'b1;
    step();

    // Vector table; the first entry also gets a start pulse mid-draw which must be ignored.
    for (int i = 0; i < 8; i++) begin
      run_col($sformatf("vec%0d", i), tbl[i].x, tbl[i].top, tbl[i].bot,
              tbl[i].c, tbl[i].w, tbl[i].f, (i == 0) ? 30 : 0);
      nc = 0; nw = 0; nf = 0;
      foreach (cap_c[k]) begin
        if (cap_c[k] == tbl[i].c) nc++;
        else if (cap_c[k] == tbl[i].w) nw++;
        else if (cap_c[k] == tbl[i].f) nf++;
      end
      check($sformatf("vec%0d ceil_count", i), nc, tbl[i].n_ceil);
      check($sformatf("vec%0d wall_count", i), nw, tbl[i].n_wall);
      check($sformatf("vec%0d floor_count", i), nf, tbl[i].n_floor);
      step();
      check($sformatf("vec%0d done_one_cycle", i), done, 0);
      check($sformatf("vec%0d idle_busy", i), busy, 0);
    end

    // Back-to-back: start held through the first column's DONE cycle.
    drive(20, 10, 60, 1, 2, 3);
    start = 1'b1;
    step();
    nwr = 0; cyc = 1;
    while (!done && cyc <= H + 20) begin
      if (vga_write) nwr++;
      step();
      cyc++;
    end
    check("b2b first done_cycle", cyc, H + 1);
    check("b2b first write_count", nwr, H);
    drive(30, 0, 50, 4, 5, 6);
    step();
    start = 1'b0;
    check("b2b second starts write", vga_write, 1);
    check("b2b second starts row", int'(vga_y), 0);
    check("b2b second starts x", int'(vga_x), 30);
    scramble();
    collect(0);
    verify("b2b second", 30, 0, 50, 4, 5, 6);
    step();

    // Reset mid-column after row 50 has been written.
    drive(40, 20, 70, 1, 2, 3);
    start = 1'b1;
    step();
    start = 1'b0;
    cyc = 1;
    while (!(vga_write && vga_y == 7'd50) && cyc <= H + 20) begin
      step();
      cyc++;
    end
    check("reset_mid row50 cycle", cyc, 51);
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    check("reset_mid write", vga_write, 0);
    check("reset_mid busy", busy, 0);
    check("reset_mid vga_y", int'(vga_y), 0);
    nwr = 0; nd = 0;
    for (int k = 0; k < H + 10; k++) begin
      if (vga_write) nwr++;
      if (done) nd++;
      step();
    end
    check("reset_mid later writes", nwr, 0);
    check("reset_mid done pulses", nd, 0);
    run_col("after_reset", 40, 20, 70, 1, 2, 3, 0);
    step();

    // Reset wins over start on the same edge.
    drive(5, 0, 127, 1, 2, 3);
    resetn = 1'b0;
    start  = 1'b1;
    step();
    resetn = 1'b1;
    start  = 1'b0;
    check("reset_vs_start busy", busy, 0);
    check("reset_vs_start write", vga_write, 0);
    step();
    check("reset_vs_start stays idle", vga_write, 0);

    for (int r = 0; r < 8; r++) begin
      rx = $urandom_range(0, 175);
      rt = $urandom_range(0, 127);
      rb = $urandom_range(0, 127);
      rc = $urandom_range(0, 7);
      rw = $urandom_range(0, 7);
      rf = $urandom_range(0, 7);
      run_col($sformatf("rand%0d", r), rx, rt, rb, rc, rw, rf, $urandom_range(0, 60));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
